// File: rtl/fsd1_pkg.sv
// Shared constants and state encoding for the FSd1 sweep scheduler.
package fsd1_pkg;

  localparam logic [7:0] CMD_F = 8'h46;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_N = 8'h4E;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_X = 8'h58;

  localparam logic [7:0] RSP_END   = 8'h45;
  localparam logic [7:0] RSP_ABORT = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_SETTLE,
    ST_DWELL,
    ST_SEND,
    ST_END,
    ST_ABORT
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

endpackage

// File: rtl/sweep_cmd_parser.sv
// Collects UART command bytes while idle and commits sweep configuration
// registers; emits go/abort pulses for the sweep sequencer.
module sweep_cmd_parser
  import fsd1_pkg::*;
#(
  parameter int unsigned FTW_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic [FTW_W-1:0] o_start,
  output logic [FTW_W-1:0] o_step,
  output logic [8:0]       o_npts,
  output logic [15:0]      o_dwell,
  output logic [1:0]       o_ch,
  output logic             o_go,
  output logic             o_abort
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cmd;
  logic             r_need2;
  logic [7:0]       r_hi;
  logic [FTW_W-1:0] r_start;
  logic [FTW_W-1:0] r_step;
  logic [8:0]       r_npts;
  logic [15:0]      r_dwell;
  logic [1:0]       r_ch;

  logic             w_go;
  logic             w_load_cmd;
  logic             w_commit;
  logic             w_hi_load;
  logic [15:0]      w_arg16;

  assign w_arg16 = {r_hi, i_rx_data};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_load_cmd  = 1'b0;
    w_commit    = 1'b0;
    w_hi_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid && i_en) begin
          case (i_rx_data)
            CMD_F, CMD_S, CMD_D, CMD_N, CMD_C: begin
              w_load_cmd  = 1'b1;
              w_state_nxt = ST_ARG;
            end
            CMD_G:   w_go = 1'b1;
            default: ;
          endcase
        end
      end
      ST_ARG: begin
        // Every byte here is argument data, 'X' included.
        if (i_rx_valid) begin
          if (r_need2) begin
            w_hi_load = 1'b1;
          end else begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd   <= '0;
      r_need2 <= 1'b0;
      r_hi    <= '0;
      r_start <= '0;
      r_step  <= '0;
      r_npts  <= 9'd1;
      r_dwell <= 16'd1;
      r_ch    <= '0;
    end else begin
      if (w_load_cmd) begin
        r_cmd   <= i_rx_data;
        r_need2 <= (i_rx_data == CMD_F) || (i_rx_data == CMD_S) || (i_rx_data == CMD_D);
      end
      if (w_hi_load) begin
        r_hi    <= i_rx_data;
        r_need2 <= 1'b0;
      end
      if (w_commit) begin
        case (r_cmd)
          CMD_F: r_start <= w_arg16;
          CMD_S: r_step  <= w_arg16;
          CMD_D: r_dwell <= (w_arg16 == 16'd0) ? 16'd1 : w_arg16;
          CMD_N: r_npts  <= (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
          CMD_C: if (i_rx_data[1:0] != 2'b11) r_ch <= i_rx_data[1:0];
          default: ;
        endcase
      end
    end
  end

  assign o_start = r_start;
  assign o_step  = r_step;
  assign o_npts  = r_npts;
  assign o_dwell = r_dwell;
  assign o_ch    = r_ch;
  assign o_go    = w_go;
  assign o_abort = i_rx_valid && !i_en && (i_rx_data == CMD_X);

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep scheduler: steps the LO tuning word point by point, integrates the
// selected mixer channel over a dwell window and streams results over UART.
module sweep_ctrl
  import fsd1_pkg::*;
#(
  parameter int unsigned FTW_W  = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic [FTW_W-1:0] lo_ftw,
  output logic             lo_en,
  input  logic [2:0]       mix_in,
  output logic             busy,
  output logic [1:0]       led
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  logic [FTW_W-1:0] w_start;
  logic [FTW_W-1:0] w_step;
  logic [8:0]       w_npts;
  logic [15:0]      w_dwell;
  logic [1:0]       w_ch;
  logic             w_go;
  logic             w_abort;

  state_t           r_state,      w_state_nxt;
  logic [FTW_W-1:0] r_ftw,        w_ftw_nxt;
  logic             r_lo_en,      w_lo_en_nxt;
  logic             r_busy,       w_busy_nxt;
  logic             r_led1,       w_led1_nxt;
  logic [7:0]       r_k,          w_k_nxt;
  logic [15:0]      r_acc,        w_acc_nxt;
  logic [7:0]       r_settle_cnt, w_settle_cnt_nxt;
  logic [15:0]      r_dwell_cnt,  w_dwell_cnt_nxt;
  logic [1:0]       r_bidx,       w_bidx_nxt;
  logic             r_abort_pend, w_abort_pend_nxt;
  logic             r_tx_valid,   w_tx_valid_nxt;
  logic [7:0]       r_tx_data,    w_tx_data_nxt;

  logic             w_sample;
  logic             w_hs;
  logic             w_last_pt;

  sweep_cmd_parser #(
    .FTW_W (FTW_W)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_state == ST_IDLE),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_start    (w_start),
    .o_step     (w_step),
    .o_npts     (w_npts),
    .o_dwell    (w_dwell),
    .o_ch       (w_ch),
    .o_go       (w_go),
    .o_abort    (w_abort)
  );

  assign w_sample  = (w_ch == 2'd0) ? mix_in[0] :
                     (w_ch == 2'd1) ? mix_in[1] : mix_in[2];
  assign w_hs      = r_tx_valid && tx_ready;
  assign w_last_pt = (({1'b0, r_k} + 9'd1) == w_npts);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ftw        <= '0;
      r_lo_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_led1       <= 1'b0;
      r_k          <= '0;
      r_acc        <= '0;
      r_settle_cnt <= '0;
      r_dwell_cnt  <= '0;
      r_bidx       <= '0;
      r_abort_pend <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ftw        <= w_ftw_nxt;
      r_lo_en      <= w_lo_en_nxt;
      r_busy       <= w_busy_nxt;
      r_led1       <= w_led1_nxt;
      r_k          <= w_k_nxt;
      r_acc        <= w_acc_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_dwell_cnt  <= w_dwell_cnt_nxt;
      r_bidx       <= w_bidx_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_tx_data    <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ftw_nxt        = r_ftw;
    w_lo_en_nxt      = r_lo_en;
    w_busy_nxt       = r_busy;
    w_led1_nxt       = r_led1;
    w_k_nxt          = r_k;
    w_acc_nxt        = r_acc;
    w_settle_cnt_nxt = r_settle_cnt;
    w_dwell_cnt_nxt  = r_dwell_cnt;
    w_bidx_nxt       = r_bidx;
    w_abort_pend_nxt = r_abort_pend;
    w_tx_valid_nxt   = r_tx_valid;
    w_tx_data_nxt    = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt      = ST_SETTLE;
          w_ftw_nxt        = w_start;
          w_lo_en_nxt      = 1'b1;
          w_busy_nxt       = 1'b1;
          w_k_nxt          = '0;
          w_acc_nxt        = '0;
          w_settle_cnt_nxt = '0;
          w_abort_pend_nxt = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (w_abort) begin
          w_state_nxt    = ST_ABORT;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = RSP_ABORT;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt     = ST_DWELL;
          w_dwell_cnt_nxt = '0;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + 8'd1;
        end
      end
      ST_DWELL: begin
        if (w_abort) begin
          w_state_nxt    = ST_ABORT;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = RSP_ABORT;
        end else begin
          if (w_sample) w_acc_nxt = sat_inc(r_acc);
          if (r_dwell_cnt == w_dwell - 16'd1) begin
            w_state_nxt    = ST_SEND;
            w_bidx_nxt     = '0;
            w_tx_valid_nxt = 1'b1;
            w_tx_data_nxt  = r_k;
          end else begin
            w_dwell_cnt_nxt = r_dwell_cnt + 16'd1;
          end
        end
      end
      ST_SEND: begin
        // An abort seen together with a handshake (or latched while waiting)
        // lets the current byte finish, then replaces the rest with 'A'.
        if (w_hs) begin
          if (r_abort_pend || w_abort) begin
            w_state_nxt      = ST_ABORT;
            w_abort_pend_nxt = 1'b0;
            w_tx_data_nxt    = RSP_ABORT;
          end else if (r_bidx == 2'd2) begin
            if (w_last_pt) begin
              w_state_nxt   = ST_END;
              w_tx_data_nxt = RSP_END;
            end else begin
              w_state_nxt      = ST_SETTLE;
              w_k_nxt          = r_k + 8'd1;
              w_ftw_nxt        = r_ftw + w_step;
              w_acc_nxt        = '0;
              w_settle_cnt_nxt = '0;
              w_tx_valid_nxt   = 1'b0;
            end
          end else begin
            w_bidx_nxt    = r_bidx + 2'd1;
            w_tx_data_nxt = (r_bidx == 2'd0) ? r_acc[15:8] : r_acc[7:0];
          end
        end else if (w_abort) begin
          w_abort_pend_nxt = 1'b1;
        end
      end
      ST_END: begin
        if (w_hs) begin
          w_state_nxt    = ST_IDLE;
          w_tx_valid_nxt = 1'b0;
          w_lo_en_nxt    = 1'b0;
          w_busy_nxt     = 1'b0;
          w_led1_nxt     = ~r_led1;
        end
      end
      ST_ABORT: begin
        if (w_hs) begin
          w_state_nxt    = ST_IDLE;
          w_tx_valid_nxt = 1'b0;
          w_lo_en_nxt    = 1'b0;
          w_busy_nxt     = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign lo_ftw   = r_ftw;
  assign lo_en    = r_lo_en;
  assign busy     = r_busy;
  assign led      = {r_led1, r_busy};

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: configuration, sweeps, backpressure, abort,
// wrap, argument edge cases and mid-transfer reset.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic [15:0] lo_ftw;
  logic        lo_en;
  logic [2:0]  mix_in;
  logic        busy;
  logic [1:0]  led;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  rx_q[$];
  logic [15:0] ftw_q[$];
  logic [7:0]  exp_q[$];

  int          rdy_mode = 0;
  int          bp_cnt   = 0;
  int          stab_err = 0;
  logic        prev_wait = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clk = ~clk;

  sweep_ctrl #(
    .FTW_W  (16),
    .SETTLE (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .lo_ftw   (lo_ftw),
    .lo_en    (lo_en),
    .mix_in   (mix_in),
    .busy     (busy),
    .led      (led)
  );

  // tx_ready: 0 = always ready, 1 = five waiting cycles per byte, 2 = never
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: begin
        if (tx_valid && bp_cnt >= 5) begin
          tx_ready = 1'b1;
          bp_cnt   = 0;
        end else begin
          tx_ready = 1'b0;
          if (tx_valid) bp_cnt++;
        end
      end
      default: tx_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      ftw_q.push_back(lo_ftw);
    end
    if (!rst && prev_wait && tx_valid && (tx_data !== prev_data)) stab_err++;
    prev_wait = !rst && tx_valid && !tx_ready;
    prev_data = tx_data;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] qb(input int i);
    return (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qf(input int i);
    return (i < ftw_q.size()) ? {16'd0, ftw_q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic cfg1(input logic [7:0] c, input logic [7:0] v);
    send(c);
    send(v);
  endtask

  task automatic cfg2(input logic [7:0] c, input logic [15:0] v);
    send(c);
    send(v[15:8]);
    send(v[7:0]);
  endtask

  task automatic go_wait(input string tag, input int max_cyc);
    int n;
    rx_q.delete();
    ftw_q.delete();
    send(8'h47);
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_b%0d", tag, i), qb(i), {24'd0, exp_q[i]});
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    mix_in   = '0;
    repeat (3) tick();
    chk("rst_ftw",   lo_ftw,   0);
    chk("rst_lo_en", lo_en,    0);
    chk("rst_txv",   tx_valid, 0);
    chk("rst_txd",   tx_data,  0);
    chk("rst_busy",  busy,     0);
    chk("rst_led",   led,      0);
    rst = 1'b0;
    tick();

    // Basic three-point sweep on channel 1
    mix_in = 3'b010;
    cfg2(8'h46, 16'h1000);
    cfg2(8'h53, 16'h0100);
    cfg1(8'h4E, 8'd3);
    cfg2(8'h44, 16'h000A);
    cfg1(8'h43, 8'd1);
    go_wait("sweep", 500);
    exp_q = '{8'h00, 8'h00, 8'h0A, 8'h01, 8'h00, 8'h0A, 8'h02, 8'h00, 8'h0A, 8'h45};
    chk_stream("sweep");
    chk("sweep_ftw0", qf(0), 32'h1000);
    chk("sweep_ftw1", qf(3), 32'h1100);
    chk("sweep_ftw2", qf(6), 32'h1200);
    chk("sweep_ftw_keep", lo_ftw, 32'h1200);
    chk("sweep_lo_en", lo_en, 0);
    chk("sweep_led", led, 2'b10);

    // Same sweep again, with backpressure
    bp_cnt   = 0;
    stab_err = 0;
    rdy_mode = 1;
    go_wait("bp", 2000);
    chk_stream("bp");
    chk("bp_stable", stab_err, 0);
    chk("bp_led", led, 2'b00);
    rdy_mode = 0;
    tick();

    // Abort during the dwell of point 1
    cfg1(8'h4E, 8'd4);
    rx_q.delete();
    ftw_q.delete();
    send(8'h47);
    n = 0;
    while (rx_q.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_first_pt", rx_q.size(), 3);
    repeat (7) tick();
    send(8'h58);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("abort_done", busy, 0);
    exp_q = '{8'h00, 8'h00, 8'h0A, 8'h41};
    chk_stream("abort");
    chk("abort_lo_en", lo_en, 0);
    chk("abort_led", led, 2'b00);

    // FTW wrap, dwell 0 stored as 1
    mix_in = 3'b111;
    cfg2(8'h46, 16'hFFF0);
    cfg2(8'h53, 16'h0020);
    cfg1(8'h4E, 8'd2);
    cfg2(8'h44, 16'h0000);
    cfg1(8'h43, 8'd0);
    go_wait("wrap", 200);
    exp_q = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h45};
    chk_stream("wrap");
    chk("wrap_ftw0", qf(0), 32'hFFF0);
    chk("wrap_ftw1", qf(3), 32'h0010);
    chk("wrap_led", led, 2'b10);

    // Longest dwell fills the accumulator
    cfg2(8'h44, 16'hFFFF);
    cfg1(8'h4E, 8'd1);
    go_wait("sat", 70000);
    exp_q = '{8'h00, 8'hFF, 8'hFF, 8'h45};
    chk_stream("sat");
    chk("sat_led", led, 2'b00);

    // N 0 means 256 points
    cfg2(8'h44, 16'h0001);
    cfg1(8'h4E, 8'd0);
    go_wait("n256", 4000);
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(8'(k));
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
    end
    exp_q.push_back(8'h45);
    chk_stream("n256");
    chk("n256_last_idx", qb(765), 32'hFF);
    chk("n256_led", led, 2'b10);

    // Channel 3 is rejected, channel 1 stays selected
    mix_in = 3'b010;
    cfg1(8'h43, 8'd1);
    cfg1(8'h43, 8'd3);
    cfg2(8'h44, 16'h0005);
    cfg1(8'h4E, 8'd1);
    go_wait("ch3", 200);
    exp_q = '{8'h00, 8'h00, 8'h05, 8'h45};
    chk_stream("ch3");
    chk("ch3_led", led, 2'b00);

    // 'X' bytes as F arguments are data
    cfg2(8'h46, 16'h5858);
    cfg2(8'h44, 16'h0001);
    chk("farg_idle", busy, 0);
    go_wait("farg", 200);
    exp_q = '{8'h00, 8'h00, 8'h01, 8'h45};
    chk_stream("farg");
    chk("farg_ftw", qf(0), 32'h5858);
    chk("farg_led", led, 2'b10);

    // Reset while a result byte is waiting
    rdy_mode = 2;
    tick();
    send(8'h47);
    n = 0;
    while (!tx_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mrst_pending", tx_valid, 1);
    rst = 1'b1;
    tick();
    chk("mrst_ftw",   lo_ftw,   0);
    chk("mrst_lo_en", lo_en,    0);
    chk("mrst_txv",   tx_valid, 0);
    chk("mrst_txd",   tx_data,  0);
    chk("mrst_busy",  busy,     0);
    chk("mrst_led",   led,      0);
    rst      = 1'b0;
    rdy_mode = 0;
    mix_in   = 3'b000;
    tick();
    go_wait("post", 200);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h45};
    chk_stream("post");
    chk("post_ftw", qf(0), 32'h0000);
    chk("post_led", led, 2'b10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
